// File: rtl/adc_decimator.sv
// -----------------------------------------------------------------------------
// adc_decimator
//
// Two-channel boxcar decimator for a signed ADC stream. While enable is high,
// N = 2^k consecutive samples per channel are summed. Each block's sum is
// shifted right arithmetically by k (floor) and presented as one result on an
// AXI-Stream style output register. A result that completes while the held
// one is still waiting for the consumer is dropped, and the sticky overflow
// flag records the drop.
//
// Ports
//   adc_clk        : sole clock, rising edge
//   adc_rstn       : asynchronous active-low reset
//   adc_dat_a_i    : channel A sample, two's complement, one per cycle
//   adc_dat_b_i    : channel B sample, two's complement, one per cycle
//   enable         : high = accumulate, low = abort current block
//   log2_dec       : requested decimation exponent k (saturated to MAX_LOG2_DEC)
//   ovf_clear      : single-cycle pulse that clears overflow
//   m_axis_tdata   : {B avg sign-extended to 16, A avg sign-extended to 16}
//   m_axis_tvalid  : result held in the output register
//   m_axis_tready  : consumer ready, handshake when tvalid && tready
//   overflow       : sticky, a completed result was dropped
//
// Assumes ADC_DATA_WIDTH <= 16, 1 <= MAX_LOG2_DEC <= 15.
// -----------------------------------------------------------------------------
module adc_decimator #(
  parameter int ADC_DATA_WIDTH = 14,
  parameter int MAX_LOG2_DEC   = 10
) (
  input  logic                             adc_clk,
  input  logic                             adc_rstn,
  input  logic signed [ADC_DATA_WIDTH-1:0] adc_dat_a_i,
  input  logic signed [ADC_DATA_WIDTH-1:0] adc_dat_b_i,
  input  logic                             enable,
  input  logic        [3:0]                log2_dec,
  input  logic                             ovf_clear,
  output logic        [31:0]               m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             overflow
);

  // Wide enough that summing 2^MAX_LOG2_DEC full-scale samples cannot wrap.
  localparam int ACC_W = ADC_DATA_WIDTH + MAX_LOG2_DEC;
  localparam int CNT_W = MAX_LOG2_DEC;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_a_q, acc_a_d;
  logic signed [ACC_W-1:0] acc_b_q, acc_b_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic        [3:0]       k_q, k_d;
  logic        [31:0]      tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // FSM: IDLE while enable is low, ACCUM while it is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state_q <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves a variable
    // unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable)  state_d = ACCUM;
      ACCUM:   if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic                    block_start;
  logic        [3:0]       k_sat;
  logic        [3:0]       k_eff;
  logic        [CNT_W:0]   n_minus_1;
  logic                    close_blk;
  logic                    handshake;
  logic signed [ACC_W-1:0] sum_a, sum_b;
  logic signed [ACC_W-1:0] shr_a, shr_b;
  logic signed [ADC_DATA_WIDTH-1:0] avg_a, avg_b;
  logic        [31:0]      result;

  always_comb begin
    // The first sample of a block is clocked on the same edge that latches k,
    // so the block-start sample must already use the fresh (saturated) value.
    block_start = (state_q == IDLE) || (cnt_q == '0);
    k_sat       = (log2_dec > 4'(MAX_LOG2_DEC)) ? 4'(MAX_LOG2_DEC) : log2_dec;
    k_eff       = block_start ? k_sat : k_q;
    n_minus_1   = ((CNT_W + 1)'(1) << k_eff) - (CNT_W + 1)'(1);
    close_blk   = enable && (cnt_q == n_minus_1[CNT_W-1:0]);
    handshake   = tvalid_q && m_axis_tready;

    sum_a = acc_a_q + ACC_W'(adc_dat_a_i);
    sum_b = acc_b_q + ACC_W'(adc_dat_b_i);
    shr_a = sum_a >>> k_eff;
    shr_b = sum_b >>> k_eff;
    // The average always fits the sample width, so the low bits carry it.
    avg_a  = shr_a[ADC_DATA_WIDTH-1:0];
    avg_b  = shr_b[ADC_DATA_WIDTH-1:0];
    result = {16'(avg_b), 16'(avg_a)};
  end

  always_comb begin
    acc_a_d  = acc_a_q;
    acc_b_d  = acc_b_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ovf_d    = ovf_q && !ovf_clear;

    if (!enable) begin
      // Abort: partial block discarded, held output untouched.
      acc_a_d = '0;
      acc_b_d = '0;
      cnt_d   = '0;
    end else begin
      if (block_start) k_d = k_sat;
      if (close_blk) begin
        acc_a_d = '0;
        acc_b_d = '0;
        cnt_d   = '0;
      end else begin
        acc_a_d = sum_a;
        acc_b_d = sum_b;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end

    if (handshake) tvalid_d = 1'b0;

    if (close_blk) begin
      // Load when the register is free or being emptied this cycle;
      // otherwise keep the held result and flag the drop (wins over clear).
      if (!tvalid_q || m_axis_tready) begin
        tdata_d  = result;
        tvalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      acc_a_q  <= '0;
      acc_b_q  <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      acc_a_q  <= acc_a_d;
      acc_b_q  <= acc_b_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_adc_decimator.sv
// -----------------------------------------------------------------------------
// tb_adc_decimator
//
// Directed bench for adc_decimator with hand-computed expected values.
// Inputs change 1 ns after a rising edge; outputs are observed at that
// same point, i.e. they show the effect of the edge just taken.
// -----------------------------------------------------------------------------
module tb_adc_decimator;

  localparam int W = 14;

  logic                adc_clk;
  logic                adc_rstn;
  logic signed [W-1:0] adc_dat_a_i;
  logic signed [W-1:0] adc_dat_b_i;
  logic                enable;
  logic        [3:0]   log2_dec;
  logic                ovf_clear;
  logic        [31:0]  m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                overflow;

  int n_checks;
  int n_pass;

  adc_decimator #(
    .ADC_DATA_WIDTH(W),
    .MAX_LOG2_DEC  (10)
  ) dut (
    .adc_clk      (adc_clk),
    .adc_rstn     (adc_rstn),
    .adc_dat_a_i  (adc_dat_a_i),
    .adc_dat_b_i  (adc_dat_b_i),
    .enable       (enable),
    .log2_dec     (log2_dec),
    .ovf_clear    (ovf_clear),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .overflow     (overflow)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge adc_clk);
    #1;
  endtask

  function automatic logic [31:0] pack(input int b, input int a);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = 16'(b);
    lo = 16'(a);
    return {hi, lo};
  endfunction

  initial begin
    int a_seq [6];
    n_checks      = 0;
    n_pass        = 0;
    adc_rstn      = 1'b0;
    adc_dat_a_i   = '0;
    adc_dat_b_i   = '0;
    enable        = 1'b0;
    log2_dec      = 4'd0;
    ovf_clear     = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state
    cyc(); cyc();
    check("rst_tvalid",   32'(m_axis_tvalid), 32'd0);
    check("rst_tdata",    m_axis_tdata,       32'd0);
    check("rst_overflow", 32'(overflow),      32'd0);
    adc_rstn = 1'b1;
    cyc();

    // k=2 block: A avg 250, B avg floor(-2.5) = -3
    log2_dec = 4'd2;
    enable   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      adc_dat_a_i = 14'(100 * i);
      adc_dat_b_i = 14'(-i);
      cyc();
      if (i < 4) check("k2_tvalid_early", 32'(m_axis_tvalid), 32'd0);
    end
    check("k2_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("k2_tdata",  m_axis_tdata, pack(-3, 250));
    enable = 1'b0;
    cyc();
    check("k2_tvalid_drop", 32'(m_axis_tvalid), 32'd0);

    // k=0 ramp: output equals input one cycle late, continuous tvalid
    log2_dec = 4'd0;
    enable   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      adc_dat_a_i = 14'(i);
      adc_dat_b_i = 14'(-i);
      cyc();
      check("k0_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("k0_tdata",  m_axis_tdata, pack(-i, i));
    end
    check("k0_no_overflow", 32'(overflow), 32'd0);
    enable = 1'b0;
    cyc();
    check("k0_tvalid_drop", 32'(m_axis_tvalid), 32'd0);

    // k=1, consumer stalled for 6 cycles: first result held, next two dropped
    a_seq    = '{10, 20, 30, 50, 60, 70};
    log2_dec = 4'd1;
    m_axis_tready = 1'b0;
    adc_dat_b_i   = '0;
    enable   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      adc_dat_a_i = 14'(a_seq[i]);
      cyc();
      if (i == 1) check("stall_ovf_before", 32'(overflow), 32'd0);
      if (i >= 1) check("stall_tdata_held", m_axis_tdata, pack(0, 15));
    end
    check("stall_tvalid",   32'(m_axis_tvalid), 32'd1);
    check("stall_overflow", 32'(overflow),      32'd1);
    enable        = 1'b0;
    m_axis_tready = 1'b1;
    cyc();
    check("stall_drain_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("ovf_sticky",         32'(overflow),      32'd1);
    ovf_clear = 1'b1;
    cyc();
    ovf_clear = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // k=3 abort after 5 samples, then a clean block of 1..8 / -1..-8
    log2_dec    = 4'd3;
    adc_dat_a_i = 14'(1000);
    adc_dat_b_i = 14'(1000);
    enable      = 1'b1;
    repeat (5) cyc();
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      adc_dat_a_i = 14'(i);
      adc_dat_b_i = 14'(-i);
      cyc();
      if (i == 7) check("abort_tvalid_early", 32'(m_axis_tvalid), 32'd0);
    end
    check("abort_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("abort_tdata",  m_axis_tdata, pack(-5, 4));
    enable = 1'b0;
    cyc();

    // log2_dec=15 saturates to 10; mid-block change to 0 must be ignored
    log2_dec    = 4'd15;
    adc_dat_a_i = -14'sd8192;
    adc_dat_b_i = 14'sd8191;
    enable      = 1'b1;
    for (int i = 1; i <= 1024; i++) begin
      if (i == 500) log2_dec = 4'd0;
      cyc();
      if (i == 1023) check("sat_tvalid_early", 32'(m_axis_tvalid), 32'd0);
    end
    check("sat_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("sat_tdata",  m_axis_tdata, pack(8191, -8192));
    enable = 1'b0;
    cyc();

    // Drop and ovf_clear in the same cycle: overflow ends high
    m_axis_tready = 1'b0;
    log2_dec      = 4'd0;
    adc_dat_a_i   = 14'(5);
    adc_dat_b_i   = '0;
    enable        = 1'b1;
    cyc();
    check("clr_race_load", m_axis_tdata, pack(0, 5));
    adc_dat_a_i = 14'(6);
    ovf_clear   = 1'b1;
    cyc();
    ovf_clear = 1'b0;
    enable    = 1'b0;
    check("clr_race_overflow", 32'(overflow),      32'd1);
    check("clr_race_held",     m_axis_tdata,       pack(0, 5));

    // Asynchronous reset mid-block with a held result
    log2_dec    = 4'd2;
    adc_dat_a_i = 14'(500);
    enable      = 1'b1;
    cyc(); cyc();
    #2;
    adc_rstn = 1'b0;
    #1;
    check("arst_tvalid",   32'(m_axis_tvalid), 32'd0);
    check("arst_tdata",    m_axis_tdata,       32'd0);
    check("arst_overflow", 32'(overflow),      32'd0);
    enable = 1'b0;
    cyc();
    adc_rstn      = 1'b1;
    m_axis_tready = 1'b1;
    log2_dec      = 4'd1;
    enable        = 1'b1;
    adc_dat_a_i   = 14'(3);
    cyc();
    check("post_rst_tvalid_early", 32'(m_axis_tvalid), 32'd0);
    adc_dat_a_i = 14'(5);
    cyc();
    check("post_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("post_rst_tdata",  m_axis_tdata, pack(0, 4));
    enable = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_decimator.md
ADC_DECIMATOR -- requirements
Module: adc_decimator

Interface
REQ-001 Parameter ADC_DATA_WIDTH, default 14, width of each signed ADC channel sample.
REQ-002 Parameter MAX_LOG2_DEC, default 10, largest supported log2 decimation ratio.
REQ-003 adc_clk  input  1  sole clock; all logic on rising edge.
REQ-004 adc_rstn  input  1  reset; asynchronous assert, active-low.
REQ-005 adc_dat_a_i  input  ADC_DATA_WIDTH  channel A sample, two's complement, one new sample per cycle.
REQ-006 adc_dat_b_i  input  ADC_DATA_WIDTH  channel B sample, two's complement, one new sample per cycle.
REQ-007 enable  input  1  high = accumulate; low = abort current block, no new results.
REQ-008 log2_dec  input  4  requested decimation exponent k; ratio N = 2^k.
REQ-009 ovf_clear  input  1  single-cycle pulse clears the overflow flag.
REQ-010 m_axis_tdata  output  32  {B avg sign-extended to 16, A avg sign-extended to 16}.
REQ-011 m_axis_tvalid  output  1  result held in the output register.
REQ-012 m_axis_tready  input  1  consumer accepts when tvalid and tready are both high.
REQ-013 overflow  output  1  sticky: a result was dropped.

Function
REQ-014 Block SHALL have two states: IDLE (enable low) and ACCUM (enable high); IDLE->ACCUM on the first cycle enable is high, ACCUM->IDLE on the first cycle enable is low.
REQ-015 On entering ACCUM and at every block start, k SHALL be latched as min(log2_dec, MAX_LOG2_DEC); log2_dec changes mid-block SHALL NOT affect the current block.
REQ-016 In ACCUM, every cycle SHALL add the sign-extended A and B samples to per-channel signed accumulators of ADC_DATA_WIDTH+MAX_LOG2_DEC bits (24 by default); overflow of an accumulator SHALL be impossible by sizing.
REQ-017 A sample counter SHALL count 0..N-1; the sample taken at count N-1 closes the block, the accumulators and counter restart at 0 with the next sample, and no sample is lost between blocks.
REQ-018 Result per channel SHALL be (sum of the N samples) arithmetically shifted right by k (floor toward negative infinity), then sign-extended to 16 bits.
REQ-019 Latency: the result SHALL appear on m_axis_tdata with tvalid high on the cycle after the closing sample is clocked in; with k=0 the block produces one result per cycle, equal to the input one cycle late.
REQ-020 tvalid SHALL stay high and tdata SHALL stay stable until a handshake; tvalid SHALL drop the cycle after a handshake unless a new result loads that same cycle.
REQ-021 If a result completes while tvalid is high and tready is low, the new result SHALL be discarded, the held one kept, and overflow SET.
REQ-022 If a result completes in the same cycle as a handshake, the new result SHALL load, tvalid SHALL stay high, and overflow SHALL NOT be set.
REQ-023 Taking ACCUM->IDLE SHALL clear the accumulators and counter, discard the partial block, and leave any held result and tvalid untouched.
REQ-024 overflow SHALL clear on ovf_clear; if ovf_clear and a new drop occur in the same cycle, overflow SHALL end high.

Reset
REQ-025 While adc_rstn is low, state SHALL be IDLE and accumulators, counter, latched k, m_axis_tdata, m_axis_tvalid, and overflow SHALL all be 0.
REQ-026 Reset asserted mid-block SHALL discard the partial block and any held result with no output handshake.
REQ-027 After adc_rstn deasserts, the first block SHALL start on the first rising edge at which enable is high.

Verification
REQ-028 k=2, enable high, A=100,200,300,400, B=-1,-2,-3,-4, tready=1 -> one result, tdata[15:0]=250, tdata[31:16]=-3 (floor of -2.5), one cycle after the 4th sample.
REQ-029 k=0, A ramp 0,1,2,... -> tvalid continuous, tdata[15:0] equals A delayed by one cycle.
REQ-030 k=1, tready=0 for 6 cycles -> first result held stable, next two results dropped, overflow=1; ovf_clear pulse -> overflow=0.
REQ-031 log2_dec=15, A constant -8192 -> k saturates to 10, result -8192 after 1024 samples.
REQ-032 k=3, enable dropped after 5 samples then raised -> partial block discarded, next result covers exactly the 8 samples after re-enable.
REQ-033 adc_rstn pulsed low mid-block with tvalid=1 -> all outputs 0 immediately (asynchronous), no handshake, accumulation restarts cleanly after release.
